// File: rtl/reg_fetch_stage.sv
// rtl/reg_fetch_stage.sv - register table with writeback bypass feeding the even-pipe execute stage
module reg_fetch_stage #(
  parameter int NUM_REGS = 128,
  parameter int WIDTH    = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [0:10]      op_in,
  input  logic [2:0]       format_in,
  input  logic [0:6]       rt_addr_in,
  input  logic [0:6]       ra_addr,
  input  logic [0:6]       rb_addr,
  input  logic [0:6]       rc_addr,
  input  logic [0:17]      imm_in,
  input  logic             reg_write_in,
  input  logic [0:WIDTH-1] wb_even_data,
  input  logic [0:6]       wb_even_addr,
  input  logic             wb_even_we,
  input  logic [0:WIDTH-1] wb_odd_data,
  input  logic [0:6]       wb_odd_addr,
  input  logic             wb_odd_we,
  output logic [0:10]      op,
  output logic [2:0]       format,
  output logic [0:6]       rt_addr,
  output logic [0:WIDTH-1] ra,
  output logic [0:WIDTH-1] rb,
  output logic [0:WIDTH-1] rc,
  output logic [0:17]      imm,
  output logic             reg_write,
  output logic             out_valid
);

  logic [0:WIDTH-1] r_table [NUM_REGS];

  logic [0:10]      r_op;
  logic [2:0]       r_format;
  logic [0:6]       r_rt_addr;
  logic [0:WIDTH-1] r_ra, r_rb, r_rc;
  logic [0:17]      r_imm;
  logic             r_reg_write;
  logic             r_out_valid;
  logic [0:6]       r_ra_addr, r_rb_addr, r_rc_addr;

  logic             w_hold;
  logic [0:6]       w_ra_sel, w_rb_sel, w_rc_sel;
  logic [0:WIDTH-1] w_ra_val, w_rb_val, w_rc_val;

  // Odd writeback is checked first so it wins when both pipes target the same entry.
  function automatic logic [0:WIDTH-1] f_bypass(
    input logic [0:6]       a,
    input logic [0:WIDTH-1] table_val,
    input logic             ev_we,
    input logic [0:6]       ev_addr,
    input logic [0:WIDTH-1] ev_data,
    input logic             od_we,
    input logic [0:6]       od_addr,
    input logic [0:WIDTH-1] od_data
  );
    if (od_we && od_addr == a)
      return od_data;
    else if (ev_we && ev_addr == a)
      return ev_data;
    else
      return table_val;
  endfunction

  assign w_hold   = stall & ~flush;
  assign w_ra_sel = w_hold ? r_ra_addr : ra_addr;
  assign w_rb_sel = w_hold ? r_rb_addr : rb_addr;
  assign w_rc_sel = w_hold ? r_rc_addr : rc_addr;

  assign w_ra_val = f_bypass(w_ra_sel, r_table[w_ra_sel], wb_even_we, wb_even_addr,
                             wb_even_data, wb_odd_we, wb_odd_addr, wb_odd_data);
  assign w_rb_val = f_bypass(w_rb_sel, r_table[w_rb_sel], wb_even_we, wb_even_addr,
                             wb_even_data, wb_odd_we, wb_odd_addr, wb_odd_data);
  assign w_rc_val = f_bypass(w_rc_sel, r_table[w_rc_sel], wb_even_we, wb_even_addr,
                             wb_even_data, wb_odd_we, wb_odd_addr, wb_odd_data);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_table[i] <= '0;
    end else begin
      if (wb_even_we)
        r_table[wb_even_addr] <= wb_even_data;
      if (wb_odd_we)
        r_table[wb_odd_addr] <= wb_odd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_op        <= '0;
      r_format    <= '0;
      r_rt_addr   <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_out_valid <= 1'b0;
      r_ra_addr   <= '0;
      r_rb_addr   <= '0;
      r_rc_addr   <= '0;
    end else if (stall) begin
      // A held bubble keeps zero operands; only a real instruction refreshes.
      if (r_out_valid) begin
        r_ra <= w_ra_val;
        r_rb <= w_rb_val;
        r_rc <= w_rc_val;
      end
    end else if (in_valid) begin
      r_op        <= op_in;
      r_format    <= format_in;
      r_rt_addr   <= rt_addr_in;
      r_ra        <= w_ra_val;
      r_rb        <= w_rb_val;
      r_rc        <= w_rc_val;
      r_imm       <= imm_in;
      r_reg_write <= reg_write_in;
      r_out_valid <= 1'b1;
      r_ra_addr   <= ra_addr;
      r_rb_addr   <= rb_addr;
      r_rc_addr   <= rc_addr;
    end else begin
      r_op        <= '0;
      r_format    <= '0;
      r_rt_addr   <= '0;
      r_ra        <= '0;
      r_rb        <= '0;
      r_rc        <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_out_valid <= 1'b0;
      r_ra_addr   <= '0;
      r_rb_addr   <= '0;
      r_rc_addr   <= '0;
    end
  end

  assign op        = r_op;
  assign format    = r_format;
  assign rt_addr   = r_rt_addr;
  assign ra        = r_ra;
  assign rb        = r_rb;
  assign rc        = r_rc;
  assign imm       = r_imm;
  assign reg_write = r_reg_write;
  assign out_valid = r_out_valid;

endmodule

// File: doc/reg_fetch_stage.md
Name: reg_fetch_stage

Overview:
- Register-fetch / operand-forwarding stage directly upstream of the even-pipe fixed-point execute stage.
- Owns the 128-entry x 128-bit register table.
- Each cycle it reads three source operands for the decoded instruction, bypasses same-cycle writebacks from the even and odd pipes, and registers the decoded fields plus operands into the execute stage's input interface.
- Fixed 1-cycle latency. Supports stall (hold) and flush (bubble insertion).

Parameters:
- NUM_REGS, 128, number of register table entries; address width is fixed at 7.
- WIDTH, 128, bits per register.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- stall  in  1  hold current outputs and re-read held source addresses.
- flush  in  1  replace the next output with a nop bubble.
- in_valid  in  1  decoded instruction present this cycle.
- op_in  in  11 [0:10]  decoded opcode, truncated per format.
- format_in  in  3 [2:0]  instruction format code.
- rt_addr_in  in  7 [0:6]  destination register address.
- ra_addr, rb_addr, rc_addr  in  7 each [0:6]  source register addresses.
- imm_in  in  18 [0:17]  immediate, truncated per format.
- reg_write_in  in  1  instruction writes the register table.
- wb_even_data  in  128 [0:127]  even-pipe writeback value.
- wb_even_addr  in  7 [0:6]  even-pipe writeback destination.
- wb_even_we  in  1  even-pipe writeback enable.
- wb_odd_data, wb_odd_addr, wb_odd_we  in  128/7/1  odd-pipe writeback, same meaning as the even-pipe signals.
- op  out  11 [0:10]  registered opcode to execute.
- format  out  3 [2:0]  registered format.
- rt_addr  out  7 [0:6]  registered destination.
- ra, rb, rc  out  128 each [0:127]  registered operand values.
- imm  out  18 [0:17]  registered immediate.
- reg_write  out  1  registered write enable.
- out_valid  out  1  output holds a real instruction.

Behaviour:
- Reset (reset==0 at posedge): all 128 register entries = 0. op, format, rt_addr, ra, rb, rc, imm, reg_write, out_valid = 0. Held address registers = 0. Reset overrides stall, flush and writeback enables.
- Register table write:
  - At each posedge with reset==1, if wb_even_we, entry[wb_even_addr] <= wb_even_data; if wb_odd_we, entry[wb_odd_addr] <= wb_odd_data.
  - Both enabled to the same address: odd port wins.
  - Writes occur regardless of stall and flush.
- Operand read:
  - ra source = wb_odd_data if wb_odd_we && wb_odd_addr==ra_addr.
  - Otherwise wb_even_data if wb_even_we && wb_even_addr==ra_addr.
  - Otherwise entry[ra_addr].
  - Same rule for rb and rc. Every register, including register 0, is ordinary and writable.
- Normal advance (stall==0, flush==0):
  - All outputs load from inputs and bypassed operands.
  - out_valid <= in_valid.
  - When in_valid==0, load a nop instead: op=0, format=0, rt_addr=0, reg_write=0, operands=0, imm=0.
  - Latency is exactly 1 cycle from input to output.
- Flush (flush==1): next outputs are a nop (as above) with out_valid=0. Flush has priority over stall.
- Stall (stall==1, flush==0):
  - op, format, rt_addr, imm, reg_write and out_valid hold their values.
  - ra/rb/rc are re-read each cycle using the held source addresses (registered alongside the instruction), with the same bypass rule.
  - This lets a held consumer pick up a writeback that lands during the stall.
  - New inputs are ignored while stalled.
- Stall released: the next posedge captures the current inputs normally. There is no skid buffer; upstream must hold its instruction while stall==1.
- Reset mid-stall: outputs go to 0 and the held instruction is discarded.
- No internal hazard detection. Stall and flush are generated externally.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 and a random op -> all outputs 0 and out_valid=0. Then a read of any register returns 0.
- Write then read: wb_even_we=1, addr=5, data=128'hA5A5..A5. Next cycle ra_addr=5 -> one cycle later ra=128'hA5A5..A5.
- Same-cycle bypass and priority: wb_even (addr 9, data 128'h1) and wb_odd (addr 9, data 128'h2) both active, with rb_addr=9 in the same cycle -> rb=128'h2. A later read of entry 9 also returns 128'h2.
- Stall refresh: instruction with ra_addr=3 captured while entry[3]=0. Assert stall for 3 cycles; in cycle 2, wb_odd writes 128'hFF to addr 3 -> ra shows 128'hFF from the following cycle. op and rt_addr are unchanged throughout.
- Flush during stall: stall=1 and flush=1 with a valid held instruction -> next cycle op=0, format=0, reg_write=0, out_valid=0.
- Pipelined stream: 4 back-to-back valid instructions, rt_addr 10..13, shlh opcode 11'b00001011111, format 0 -> outputs appear in order with 1-cycle latency and no bubbles.
